// File: rtl/branch_update_queue.sv
// Replays resolved branch outcomes into a BHT write port as ALLOC/UPDATE pairs:
// the first cycle allocates a missing tag, the second steps its counter.
module branch_update_queue #(
  parameter int unsigned INDEX_LEN = 7,
  parameter int unsigned TAG_LEN   = 7,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic [INDEX_LEN-1:0]   push_index,
  input  logic [TAG_LEN-1:0]     push_tag,
  input  logic                   push_taken,
  output logic [INDEX_LEN-1:0]   bht_index_write,
  output logic [TAG_LEN-1:0]     bht_tag_write,
  output logic                   bht_increment_decrement,
  output logic                   bht_write_enabled,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [INDEX_LEN-1:0] index;
    logic [TAG_LEN-1:0]   tag;
    logic                 taken;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALLOC  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  entry_t          last_q, last_d;
  entry_t          head;
  logic            push_fire;
  logic            pop;

  assign head       = mem_q[rd_ptr_q];
  assign push_ready = (count_q < CW'(DEPTH)) && !flush;
  assign push_fire  = push_valid && push_ready;
  assign count      = count_q;
  assign empty      = (count_q == '0);

  // Next-state, pointer bookkeeping and BHT write-port drive
  always_comb begin
    state_d                 = state_q;
    wr_ptr_d                = wr_ptr_q;
    rd_ptr_d                = rd_ptr_q;
    last_d                  = last_q;
    pop                     = 1'b0;
    bht_index_write         = last_q.index;
    bht_tag_write           = last_q.tag;
    bht_increment_decrement = last_q.taken;
    bht_write_enabled       = 1'b0;

    pop     = (state_q == UPDATE);
    count_d = count_q + CW'(push_fire) - CW'(pop);

    case (state_q)
      IDLE: begin
        if (count_q != '0) state_d = ALLOC;
      end
      ALLOC: begin
        bht_index_write         = head.index;
        bht_tag_write           = head.tag;
        bht_increment_decrement = head.taken;
        state_d                 = UPDATE;
      end
      UPDATE: begin
        bht_index_write         = head.index;
        bht_tag_write           = head.tag;
        bht_increment_decrement = head.taken;
        bht_write_enabled       = 1'b1;
        last_d                  = head;
        state_d                 = (count_d != '0) ? ALLOC : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (push_fire) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)       rd_ptr_d = rd_ptr_q + PW'(1);

    // Flush drops the queue but keeps last_* so idle outputs stay stable
    if (flush) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_fire) begin
      mem_q[wr_ptr_q] <= entry_t'{index: push_index, tag: push_tag, taken: push_taken};
    end
  end

endmodule

// File: tb/tb_branch_update_queue.sv
// Bench for branch_update_queue: vector table, directed corner sequences and
// random traffic against a queue-level reference model plus a tiny BHT model.
module tb_branch_update_queue;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [6:0] index;
    logic [6:0] tag;
    logic       taken;
  } ent_t;

  typedef struct {
    bit pv; int ix; int tg; bit tk;
    bit we; int eix; int etg; bit einc; int ecnt; bit erdy;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0, flush = 1'b0, push_valid = 1'b0, push_taken = 1'b0;
  logic [6:0] push_index = '0, push_tag = '0;
  logic       push_ready, bht_increment_decrement, bht_write_enabled, empty;
  logic [6:0] bht_index_write, bht_tag_write;
  logic [2:0] count;

  always #5 clk = ~clk;

  branch_update_queue #(.INDEX_LEN(7), .TAG_LEN(7), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_index(push_index), .push_tag(push_tag), .push_taken(push_taken),
    .bht_index_write(bht_index_write), .bht_tag_write(bht_tag_write),
    .bht_increment_decrement(bht_increment_decrement),
    .bht_write_enabled(bht_write_enabled), .count(count), .empty(empty)
  );

  int total = 0, passed = 0, cyc = 0;

  // reference model: queue contents, retire phase (0 idle, 1 alloc, 2 update), last written entry
  ent_t mq[$];
  int   mphase = 0;
  ent_t mlast = '0;
  bit   mvalid = 1'b0;

  logic s_ready, s_we, s_inc, s_empty;
  logic [6:0] s_idx, s_tag;
  int   s_cnt;

  int   bht[int];
  int   trace[$];
  int   trace_key = -1;
  int   we_cyc[$];
  ent_t we_ent[$];

  function automatic void chk(string n, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
  endfunction

  task automatic step(input bit r, input bit f, input bit pv,
                      input logic [6:0] ix, input logic [6:0] tg, input bit tk);
    ent_t eo;
    int   key;
    bit   fire;
    reset = r; flush = f; push_valid = pv;
    push_index = ix; push_tag = tg; push_taken = tk;
    #1;
    s_ready = push_ready; s_we = bht_write_enabled; s_inc = bht_increment_decrement;
    s_idx = bht_index_write; s_tag = bht_tag_write; s_cnt = int'(count); s_empty = empty;
    if (mvalid) begin
      eo = (mphase != 0) ? mq[0] : mlast;
      chk("model_ready", int'(s_ready), int'((mq.size() < DEPTH) && !f));
      chk("model_we",    int'(s_we),    int'(mphase == 2));
      chk("model_index", int'(s_idx),   int'(eo.index));
      chk("model_tag",   int'(s_tag),   int'(eo.tag));
      chk("model_incdec", int'(s_inc),  int'(eo.taken));
      chk("model_count", s_cnt,         mq.size());
      chk("model_empty", int'(s_empty), int'(mq.size() == 0));
    end
    if (s_we) begin
      we_cyc.push_back(cyc);
      we_ent.push_back('{index: s_idx, tag: s_tag, taken: s_inc});
    end
    fire = pv && (mq.size() < DEPTH) && !f;
    @(posedge clk);
    if (!r) begin
      key = int'({s_idx, s_tag});
      if (!bht.exists(key)) bht[key] = 1;
      else if (s_we) begin
        if (s_inc && bht[key] < 3) bht[key] = bht[key] + 1;
        else if (!s_inc && bht[key] > 0) bht[key] = bht[key] - 1;
        if (key == trace_key) trace.push_back(bht[key]);
      end
    end
    if (r) begin
      mq.delete(); mphase = 0; mlast = '0; mvalid = 1'b1;
    end else if (f) begin
      if (mphase == 2) mlast = mq[0];
      mq.delete(); mphase = 0;
    end else begin
      int pre;
      pre = mq.size();
      if (mphase == 2) begin mlast = mq[0]; void'(mq.pop_front()); end
      if (fire) mq.push_back('{index: ix, tag: tg, taken: tk});
      if (mphase == 0)      mphase = (pre != 0) ? 1 : 0;
      else if (mphase == 1) mphase = 2;
      else                  mphase = (mq.size() != 0) ? 1 : 0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 1'b0);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      if (mq.size() == 0 && mphase == 0) done = 1'b1;
      else idle_step();
    end
    chk("drain_done", int'(done), 1);
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1, 5, 'h2A, 1,  0, 0, 0,    0, 0, 1};
    tbl[1]  = '{0, 0, 0,    0,  0, 0, 0,    0, 1, 1};
    tbl[2]  = '{0, 0, 0,    0,  0, 5, 'h2A, 1, 1, 1};
    tbl[3]  = '{0, 0, 0,    0,  1, 5, 'h2A, 1, 1, 1};
    tbl[4]  = '{0, 0, 0,    0,  0, 5, 'h2A, 1, 0, 1};
    tbl[5]  = '{1, 3, 'h11, 0,  0, 5, 'h2A, 1, 0, 1};
    tbl[6]  = '{0, 0, 0,    0,  0, 5, 'h2A, 1, 1, 1};
    tbl[7]  = '{0, 0, 0,    0,  0, 3, 'h11, 0, 1, 1};
    tbl[8]  = '{1, 9, 'h44, 1,  1, 3, 'h11, 0, 1, 1};
    tbl[9]  = '{0, 0, 0,    0,  0, 9, 'h44, 1, 1, 1};
    tbl[10] = '{0, 0, 0,    0,  1, 9, 'h44, 1, 1, 1};
    tbl[11] = '{0, 0, 0,    0,  0, 9, 'h44, 1, 0, 1};

    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, 7'd0, 7'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 7'd0, 7'd0, 1'b0);

    // single push latency, then push coinciding with UPDATE at count 1
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, tbl[i].pv, 7'(tbl[i].ix), 7'(tbl[i].tg), tbl[i].tk);
      chk("tbl_we",    int'(s_we),    int'(tbl[i].we));
      chk("tbl_index", int'(s_idx),   tbl[i].eix);
      chk("tbl_tag",   int'(s_tag),   tbl[i].etg);
      chk("tbl_incdec", int'(s_inc),  int'(tbl[i].einc));
      chk("tbl_count", s_cnt,         tbl[i].ecnt);
      chk("tbl_ready", int'(s_ready), int'(tbl[i].erdy));
    end
    begin
      int k = int'({7'd5, 7'h2A});
      chk("bht_single_counter", bht.exists(k) ? bht[k] : -1, 2);
    end

    // fill to full, hold a push, retire in order with no idle gap
    begin
      int nxt = 1;
      bit saw_full = 1'b0;
      drain();
      we_cyc.delete(); we_ent.delete();
      for (int i = 0; i < 60 && nxt <= 6; i++) begin
        step(1'b0, 1'b0, 1'b1, 7'(nxt), 7'(nxt + 16), 1'(nxt & 1));
        if (s_ready) nxt++;
        else saw_full = 1'b1;
      end
      chk("fill_all_pushed", nxt, 7);
      chk("fill_full_seen", int'(saw_full), 1);
      drain();
      chk("fill_retire_count", we_ent.size(), 6);
      for (int k = 0; k < we_ent.size() && k < 6; k++) begin
        chk("fill_order_index", int'(we_ent[k].index), k + 1);
        chk("fill_order_tag",   int'(we_ent[k].tag),   k + 17);
      end
      for (int k = 1; k < we_cyc.size() && k < 6; k++)
        chk("fill_no_gap", we_cyc[k] - we_cyc[k-1], 2);
    end

    // same index/tag three times, taken: counter 01->10->11->11
    drain();
    bht.delete(); trace.delete();
    trace_key = int'({7'd20, 7'h33});
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 7'd20, 7'h33, 1'b1);
    drain();
    chk("same_we_pulses", trace.size(), 3);
    if (trace.size() == 3) begin
      chk("same_cnt_1", trace[0], 2);
      chk("same_cnt_2", trace[1], 3);
      chk("same_cnt_3", trace[2], 3);
    end
    trace_key = -1;

    // flush during ALLOC with three queued
    drain();
    step(1'b0, 1'b0, 1'b1, 7'd11, 7'h21, 1'b1);
    step(1'b0, 1'b0, 1'b1, 7'd12, 7'h22, 1'b0);
    step(1'b0, 1'b0, 1'b1, 7'd13, 7'h23, 1'b1);
    step(1'b0, 1'b0, 1'b1, 7'd14, 7'h24, 1'b0);
    step(1'b0, 1'b1, 1'b1, 7'd15, 7'h25, 1'b1);
    chk("flush_pre_count", s_cnt, 3);
    chk("flush_pre_we", int'(s_we), 0);
    chk("flush_pre_index", int'(s_idx), 12);
    chk("flush_pre_ready", int'(s_ready), 0);
    idle_step();
    chk("flush_count", s_cnt, 0);
    chk("flush_empty", int'(s_empty), 1);
    chk("flush_we", int'(s_we), 0);
    chk("flush_hold_index", int'(s_idx), 11);
    chk("flush_hold_tag", int'(s_tag), 'h21);
    chk("flush_hold_incdec", int'(s_inc), 1);
    for (int i = 0; i < 3; i++) begin
      idle_step();
      chk("flush_quiet_we", int'(s_we), 0);
    end

    // reset during UPDATE with two queued
    drain();
    step(1'b0, 1'b0, 1'b1, 7'd30, 7'h30, 1'b1);
    step(1'b0, 1'b0, 1'b1, 7'd31, 7'h31, 1'b0);
    idle_step();
    step(1'b1, 1'b0, 1'b0, 7'd0, 7'd0, 1'b0);
    chk("rst_pre_we", int'(s_we), 1);
    chk("rst_pre_count", s_cnt, 2);
    idle_step();
    chk("rst_index", int'(s_idx), 0);
    chk("rst_tag", int'(s_tag), 0);
    chk("rst_incdec", int'(s_inc), 0);
    chk("rst_we", int'(s_we), 0);
    chk("rst_count", s_cnt, 0);
    chk("rst_ready", int'(s_ready), 1);
    for (int i = 0; i < 4; i++) begin
      idle_step();
      chk("rst_quiet_we", int'(s_we), 0);
    end

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      bit r, f, pv;
      r  = ($urandom_range(0, 199) == 0);
      f  = ($urandom_range(0, 99) < 3);
      pv = ($urandom_range(0, 99) < 60);
      step(r, f, pv, 7'($urandom), 7'($urandom_range(0, 7)), 1'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
